// File: rtl/projection_histogram_pkg.sv
// Shared types, defaults and arithmetic helpers for the x/y projection histogram.
package projection_histogram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DEF_IMWIDTH  = 240;
    localparam int DEF_IMHEIGHT = 180;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_COUNT_W  = 8;
    localparam int DEF_TOTAL_W  = 16;

    // Ceiling log2, never below 1 so single-entry arrays still get an index bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit field (w < 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = 32'((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/histogram_axis.sv
// One projection axis: bin store, saturating accumulate, clear port,
// valid/ready read-out stream and running-median tracker.
module histogram_axis
    import projection_histogram_pkg::*;
#(
    parameter int DEPTH   = DEF_IMWIDTH,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int TOTAL_W = DEF_TOTAL_W,
    parameter int IDX_W   = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               inc_en,
    input  logic [IDX_W-1:0]   inc_addr,
    output logic               inc_sat,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic               rd_start,
    input  logic               rd_ready,
    input  logic [TOTAL_W-1:0] total,
    output logic [COUNT_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_last,
    output logic               rd_done,
    output logic [IDX_W-1:0]   median
);

    localparam int AW = clog2(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [COUNT_W-1:0] bin_mem [DEPTH];

    logic [COUNT_W-1:0] inc_old;
    logic [COUNT_W-1:0] inc_new;
    logic               clr_in_range;

    logic [IDX_W-1:0]   rd_idx_reg;
    logic [COUNT_W-1:0] rd_data_reg;
    logic               rd_valid_reg;
    logic               rd_done_reg;
    logic [TOTAL_W:0]   cum_reg;
    logic               found_reg;
    logic [IDX_W-1:0]   median_reg;

    logic               accept;
    logic [TOTAL_W:0]   cum_next;
    logic               hit;

    assign inc_old      = bin_mem[AW'(inc_addr)];
    assign inc_new      = COUNT_W'(sat_inc(32'(inc_old), COUNT_W));
    assign inc_sat      = inc_en && (inc_old == '1);
    assign clr_in_range = ({1'b0, clr_idx} < DEPTH_L);

    // Combinational read keeps the accumulate a one-cycle read-modify-write,
    // so back-to-back hits on one bin chain through correctly.
    always_ff @(posedge clk) begin
        if (clr_en && clr_in_range) begin
            bin_mem[AW'(clr_idx)] <= '0;
        end else if (inc_en) begin
            bin_mem[AW'(inc_addr)] <= inc_new;
        end
    end

    assign accept   = rd_valid_reg && rd_ready;
    assign rd_last  = accept && (rd_idx_reg == LAST_IDX);
    assign cum_next = cum_reg + (TOTAL_W + 1)'(rd_data_reg);
    // 2*cum >= total, evaluated one bit wider so the doubling cannot wrap.
    assign hit      = accept && !found_reg && ({cum_next, 1'b0} >= {2'b00, total});

    // Bins that saturated can leave half the total unreached; fall back to the last bin.
    always_comb begin
        median = median_reg;
        if (hit) begin
            median = rd_idx_reg;
        end else if (rd_last && !found_reg) begin
            median = LAST_IDX;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_idx_reg   <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_done_reg  <= 1'b0;
            cum_reg      <= '0;
            found_reg    <= 1'b0;
            median_reg   <= '0;
        end else if (rd_start) begin
            rd_idx_reg   <= '0;
            rd_valid_reg <= 1'b1;
            rd_done_reg  <= 1'b0;
            cum_reg      <= '0;
            found_reg    <= 1'b0;
            median_reg   <= '0;
            // A pixel landing on bin 0 in the start cycle must show in the first beat.
            rd_data_reg  <= (inc_en && inc_addr == '0) ? inc_new : bin_mem[0];
        end else if (accept) begin
            cum_reg    <= cum_next;
            found_reg  <= found_reg | hit;
            median_reg <= median;
            if (rd_last) begin
                rd_valid_reg <= 1'b0;
                rd_done_reg  <= 1'b1;
            end else begin
                rd_idx_reg  <= rd_idx_reg + 1'b1;
                rd_data_reg <= bin_mem[AW'(rd_idx_reg + 1'b1)];
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_done  = rd_done_reg;

endmodule

// File: rtl/projection_histogram.sv
// X/Y projection histogram for binary event frames: accumulate, stream out with
// running medians, and sweep-clear; FSM, total counter and sticky flags live here.
module projection_histogram
    import projection_histogram_pkg::*;
#(
    parameter int IMWIDTH  = DEF_IMWIDTH,
    parameter int IMHEIGHT = DEF_IMHEIGHT,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COUNT_W  = DEF_COUNT_W,
    parameter int TOTAL_W  = DEF_TOTAL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  xAddress,
    input  logic [ADDR_W-1:0]  yAddress,
    input  logic               pixelData,
    input  logic               pixelValid,
    input  logic               startRead,
    input  logic               startClear,
    input  logic               outReady,
    output logic [COUNT_W-1:0] xHistogramOut,
    output logic [COUNT_W-1:0] yHistogramOut,
    output logic               xValid,
    output logic               yValid,
    output logic [ADDR_W-1:0]  xMedian,
    output logic [ADDR_W-1:0]  yMedian,
    output logic               medianValid,
    output logic               busy,
    output logic               histogramClear,
    output logic               saturated,
    output logic               pixelDropped,
    output logic               addrError
);

    localparam int MAXD  = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
    localparam int IDX_W = clog2(MAXD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAXD - 1);
    localparam logic [ADDR_W:0]  X_LIM    = (ADDR_W + 1)'(IMWIDTH);
    localparam logic [ADDR_W:0]  Y_LIM    = (ADDR_W + 1)'(IMHEIGHT);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [TOTAL_W-1:0] total_reg;
    logic               saturated_reg;
    logic               dropped_reg;
    logic               addr_err_reg;
    logic [ADDR_W-1:0]  x_median_reg;
    logic [ADDR_W-1:0]  y_median_reg;
    logic               median_valid_reg;
    logic               hist_clear_reg;

    logic               pix;
    logic               addr_ok;
    logic               inc_en;
    logic               rd_start;
    logic               clr_en;
    logic               read_done;

    logic               x_sat, y_sat;
    logic               x_last, y_last;
    logic               x_done, y_done;
    logic [IDX_W-1:0]   x_med, y_med;

    assign pix      = pixelValid && pixelData;
    assign addr_ok  = ({1'b0, xAddress} < X_LIM) && ({1'b0, yAddress} < Y_LIM);
    assign inc_en   = !reset && (state_reg == IDLE) && pix && addr_ok;
    assign rd_start = !reset && (state_reg == IDLE) && startRead;
    assign clr_en   = !reset && (state_reg == CLEAR);

    histogram_axis #(
        .DEPTH   (IMWIDTH),
        .COUNT_W (COUNT_W),
        .TOTAL_W (TOTAL_W),
        .IDX_W   (IDX_W)
    ) x_axis (
        .clk      (clk),
        .srst     (reset),
        .inc_en   (inc_en),
        .inc_addr (IDX_W'(xAddress)),
        .inc_sat  (x_sat),
        .clr_en   (clr_en),
        .clr_idx  (idx_reg),
        .rd_start (rd_start),
        .rd_ready (outReady),
        .total    (total_reg),
        .rd_data  (xHistogramOut),
        .rd_valid (xValid),
        .rd_last  (x_last),
        .rd_done  (x_done),
        .median   (x_med)
    );

    histogram_axis #(
        .DEPTH   (IMHEIGHT),
        .COUNT_W (COUNT_W),
        .TOTAL_W (TOTAL_W),
        .IDX_W   (IDX_W)
    ) y_axis (
        .clk      (clk),
        .srst     (reset),
        .inc_en   (inc_en),
        .inc_addr (IDX_W'(yAddress)),
        .inc_sat  (y_sat),
        .clr_en   (clr_en),
        .clr_idx  (idx_reg),
        .rd_start (rd_start),
        .rd_ready (outReady),
        .total    (total_reg),
        .rd_data  (yHistogramOut),
        .rd_valid (yValid),
        .rd_last  (y_last),
        .rd_done  (y_done),
        .median   (y_med)
    );

    assign read_done = (x_last || x_done) && (y_last || y_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= CLEAR;
            idx_reg          <= '0;
            total_reg        <= '0;
            saturated_reg    <= 1'b0;
            dropped_reg      <= 1'b0;
            addr_err_reg     <= 1'b0;
            x_median_reg     <= '0;
            y_median_reg     <= '0;
            median_valid_reg <= 1'b0;
            hist_clear_reg   <= 1'b0;
        end else begin
            median_valid_reg <= 1'b0;
            hist_clear_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (inc_en) begin
                        total_reg <= TOTAL_W'(sat_inc(32'(total_reg), TOTAL_W));
                        if (x_sat || y_sat || total_reg == '1) saturated_reg <= 1'b1;
                    end
                    if (pix && !addr_ok) addr_err_reg <= 1'b1;
                    if (startRead) begin
                        state_reg <= READ;
                    end else if (startClear) begin
                        // Wiping the total and flags up front lets pixels dropped
                        // during the sweep still raise pixelDropped.
                        state_reg     <= CLEAR;
                        idx_reg       <= '0;
                        total_reg     <= '0;
                        saturated_reg <= 1'b0;
                        dropped_reg   <= 1'b0;
                        addr_err_reg  <= 1'b0;
                    end
                end
                READ: begin
                    if (pixelValid) dropped_reg <= 1'b1;
                    if (read_done) begin
                        state_reg        <= IDLE;
                        median_valid_reg <= 1'b1;
                        x_median_reg     <= ADDR_W'(x_med);
                        y_median_reg     <= ADDR_W'(y_med);
                    end
                end
                CLEAR: begin
                    if (pixelValid) dropped_reg <= 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg      <= IDLE;
                        idx_reg        <= '0;
                        hist_clear_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    // Combinational so the post-reset sweep reads busy from its very first cycle.
    assign busy           = (state_reg != IDLE) && !reset;
    assign xMedian        = x_median_reg;
    assign yMedian        = y_median_reg;
    assign medianValid    = median_valid_reg;
    assign histogramClear = hist_clear_reg;
    assign saturated      = saturated_reg;
    assign pixelDropped   = dropped_reg;
    assign addrError      = addr_err_reg;

endmodule

// File: tb/tb_projection_histogram.sv
// Randomised bench for projection_histogram against a count-array reference model.
module tb_projection_histogram;

    localparam int W = 240;
    localparam int H = 180;
    localparam int RD_LIMIT = 3000;

    logic       clk;
    logic       reset;
    logic [7:0] xAddress, yAddress;
    logic       pixelData, pixelValid, startRead, startClear, outReady;
    logic [7:0] xHistogramOut, yHistogramOut;
    logic       xValid, yValid;
    logic [7:0] xMedian, yMedian;
    logic       medianValid, busy, histogramClear, saturated, pixelDropped, addrError;

    projection_histogram dut (
        .clk            (clk),
        .reset          (reset),
        .xAddress       (xAddress),
        .yAddress       (yAddress),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .startRead      (startRead),
        .startClear     (startClear),
        .outReady       (outReady),
        .xHistogramOut  (xHistogramOut),
        .yHistogramOut  (yHistogramOut),
        .xValid         (xValid),
        .yValid         (yValid),
        .xMedian        (xMedian),
        .yMedian        (yMedian),
        .medianValid    (medianValid),
        .busy           (busy),
        .histogramClear (histogramClear),
        .saturated      (saturated),
        .pixelDropped   (pixelDropped),
        .addrError      (addrError)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: plain per-bin counts, total and flags.
    int mx[W];
    int my[H];
    int mtotal;
    bit m_sat, m_addr, m_drop;

    // Read capture.
    int rx[W];
    int ry[H];
    int rx_n, ry_n, mv_cyc, last_x_cyc, hold_err, hc_seen;
    logic [7:0] cap_xm, cap_ym;

    function automatic void model_clear();
        for (int i = 0; i < W; i++) mx[i] = 0;
        for (int i = 0; i < H; i++) my[i] = 0;
        mtotal = 0;
        m_sat = 0; m_addr = 0; m_drop = 0;
    endfunction

    function automatic void model_pix(input int x, input int y);
        if (x >= W || y >= H) begin
            m_addr = 1;
        end else begin
            if (mx[x] == 255 || my[y] == 255 || mtotal == 65535) m_sat = 1;
            if (mx[x] < 255) mx[x]++;
            if (my[y] < 255) my[y]++;
            if (mtotal < 65535) mtotal++;
        end
    endfunction

    function automatic int med_ref(input bit is_y);
        int cum;
        int n;
        cum = 0;
        n = is_y ? H : W;
        for (int i = 0; i < n; i++) begin
            cum += is_y ? my[i] : mx[i];
            if (2 * cum >= mtotal) return i;
        end
        return n - 1;
    endfunction

    function automatic int count_bin_errs();
        int e;
        e = 0;
        for (int i = 0; i < W; i++) if (rx[i] != mx[i]) e++;
        for (int i = 0; i < H; i++) if (ry[i] != my[i]) e++;
        return e;
    endfunction

    task automatic send_pix(input int x, input int y);
        pixelValid = 1; pixelData = 1;
        xAddress = 8'(x); yAddress = 8'(y);
        model_pix(x, y);
        @(negedge clk);
        pixelValid = 0;
    endtask

    // Drives a read from the current negedge; mode 0 full rate, 1 pattern 1001, 2 random.
    task automatic run_read(input int mode, input bit with_clear, input int pix_cyc);
        int cyc;
        bit rdy, px_hold, py_hold;
        logic [7:0] px_data, py_data;
        for (int i = 0; i < W; i++) rx[i] = -1;
        for (int i = 0; i < H; i++) ry[i] = -1;
        rx_n = 0; ry_n = 0; mv_cyc = -1; last_x_cyc = -1; hold_err = 0; hc_seen = 0;
        px_hold = 0; py_hold = 0; px_data = 0; py_data = 0;
        startRead = 1; startClear = with_clear; outReady = 1;
        @(negedge clk);
        startRead = 0; startClear = 0; pixelValid = 0;
        cyc = 1;
        while (cyc < RD_LIMIT) begin
            if (histogramClear) hc_seen++;
            if (px_hold && (!xValid || xHistogramOut !== px_data)) hold_err++;
            if (py_hold && (!yValid || yHistogramOut !== py_data)) hold_err++;
            if (medianValid) begin
                mv_cyc = cyc; cap_xm = xMedian; cap_ym = yMedian;
                break;
            end
            case (mode)
                0:       rdy = 1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            outReady = rdy;
            pixelValid = (cyc == pix_cyc); pixelData = 1; xAddress = 8'd1; yAddress = 8'd1;
            if (xValid && rdy) begin
                if (rx_n < W) rx[rx_n] = int'(xHistogramOut);
                rx_n++; last_x_cyc = cyc;
            end
            if (yValid && rdy) begin
                if (ry_n < H) ry[ry_n] = int'(yHistogramOut);
                ry_n++;
            end
            px_hold = xValid && !rdy; px_data = xHistogramOut;
            py_hold = yValid && !rdy; py_data = yHistogramOut;
            @(negedge clk);
            cyc++;
        end
        pixelValid = 0; outReady = 1;
    endtask

    task automatic do_clear(output int hc_at, output int busy_cnt);
        int k;
        startClear = 1;
        @(negedge clk);
        startClear = 0;
        k = 1; hc_at = -1; busy_cnt = 0;
        while (k < 1000) begin
            if (histogramClear) begin hc_at = k; break; end
            if (busy) busy_cnt++;
            @(negedge clk); k++;
        end
        model_clear();
    endtask

    task automatic release_reset(output int hc_at, output int busy_cnt);
        int k;
        reset = 0;
        #1;
        k = 1; hc_at = -1; busy_cnt = 0;
        while (k < 1000) begin
            if (histogramClear) begin hc_at = k; break; end
            if (busy) busy_cnt++;
            @(negedge clk); k++;
        end
        model_clear();
    endtask

    task automatic test_reset();
        int hc_at, bc;
        logic [63:0] outs;
        reset = 1;
        repeat (3) @(negedge clk);
        outs = {xHistogramOut, yHistogramOut, xValid, yValid, xMedian, yMedian, medianValid,
                busy, histogramClear, saturated, pixelDropped, addrError};
        checks++;
        if (outs !== 64'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        release_reset(hc_at, bc);
        checks++;
        if (bc !== 240) begin errors++; $display("FAIL reset_busy_cycles: got %0d want 240", bc); end
        checks++;
        if (hc_at !== 241) begin errors++; $display("FAIL reset_clear_done: got cycle %0d want 241", hc_at); end
        $display("reset: busy %0d cycles, histogramClear at %0d", bc, hc_at);
    endtask

    task automatic test_basic();
        int e;
        repeat (3) send_pix(5, 7);
        send_pix(200, 179);
        checks++;
        if ({saturated, addrError} !== 2'b00) begin
            errors++; $display("FAIL basic_flags: got %b want 00", {saturated, addrError});
        end
        run_read(0, 0, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || rx_n !== W || ry_n !== H) begin
            errors++; $display("FAIL basic_bins: %0d wrong bins, x beats %0d y beats %0d, want 0/%0d/%0d", e, rx_n, ry_n, W, H);
        end
        checks++;
        if (int'(cap_xm) !== med_ref(0) || int'(cap_ym) !== med_ref(1)) begin
            errors++; $display("FAIL basic_median: got %0d/%0d want %0d/%0d", cap_xm, cap_ym, med_ref(0), med_ref(1));
        end
        checks++;
        if (mv_cyc !== 241) begin errors++; $display("FAIL basic_mv_time: got %0d want 241", mv_cyc); end
        checks++;
        if ({xValid, yValid, busy} !== 3'b000) begin
            errors++; $display("FAIL basic_end_state: got %b want 000", {xValid, yValid, busy});
        end
        @(negedge clk);
        checks++;
        if (medianValid !== 1'b0 || xMedian !== cap_xm || yMedian !== cap_ym) begin
            errors++; $display("FAIL basic_mv_pulse: mv %b med %0d/%0d want 0 %0d/%0d", medianValid, xMedian, yMedian, cap_xm, cap_ym);
        end
        $display("basic: xMedian %0d yMedian %0d medianValid at %0d", cap_xm, cap_ym, mv_cyc);
    endtask

    task automatic test_saturate();
        int e;
        for (int i = 0; i < 300; i++) send_pix(0, 0);
        checks++;
        if (saturated !== m_sat) begin errors++; $display("FAIL sat_flag: got %b want %b", saturated, m_sat); end
        run_read(0, 0, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || rx[0] !== 255 || ry[0] !== 255) begin
            errors++; $display("FAIL sat_bins: %0d wrong, x0 %0d y0 %0d want 255", e, rx[0], ry[0]);
        end
        checks++;
        if (int'(cap_xm) !== med_ref(0) || int'(cap_ym) !== med_ref(1)) begin
            errors++; $display("FAIL sat_median: got %0d/%0d want %0d/%0d", cap_xm, cap_ym, med_ref(0), med_ref(1));
        end
        $display("saturate: total %0d xMedian %0d", mtotal, cap_xm);
    endtask

    task automatic test_addr_drop();
        int e;
        send_pix(240, 3);
        send_pix(3, 180);
        checks++;
        if ({addrError, pixelDropped} !== {m_addr, 1'b0}) begin
            errors++; $display("FAIL addr_flag: got %b want %b0", {addrError, pixelDropped}, m_addr);
        end
        run_read(0, 0, 50);
        m_drop = 1;
        checks++;
        if (pixelDropped !== m_drop) begin errors++; $display("FAIL drop_flag: got %b want 1", pixelDropped); end
        e = count_bin_errs();
        checks++;
        if (e !== 0 || int'(cap_xm) !== med_ref(0)) begin
            errors++; $display("FAIL addr_drop_bins: %0d wrong, xMedian %0d want %0d", e, cap_xm, med_ref(0));
        end
        $display("addr_drop: addrError %b pixelDropped %b", addrError, pixelDropped);
    endtask

    task automatic test_random(input int mode);
        int hc_at, bc, n, e, x, y;
        bit v, d;
        do_clear(hc_at, bc);
        checks++;
        if (hc_at !== 241 || bc !== 240) begin
            errors++; $display("FAIL rand_clear: hc %0d busy %0d want 241/240", hc_at, bc);
        end
        n = $urandom_range(40, 160);
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1);
            v = 1'($urandom_range(0, 3) != 0); d = 1'($urandom_range(0, 4) != 0);
            pixelValid = v; pixelData = d; xAddress = 8'(x); yAddress = 8'(y);
            if (v && d) model_pix(x, y);
            @(negedge clk);
        end
        pixelValid = 0;
        run_read(mode, 0, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || rx_n !== W || ry_n !== H) begin
            errors++; $display("FAIL rand_bins: %0d wrong, beats %0d/%0d want 0 %0d/%0d", e, rx_n, ry_n, W, H);
        end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL rand_hold: %0d unstable beats want 0", hold_err); end
        checks++;
        if (int'(cap_xm) !== med_ref(0) || int'(cap_ym) !== med_ref(1)) begin
            errors++; $display("FAIL rand_median: got %0d/%0d want %0d/%0d", cap_xm, cap_ym, med_ref(0), med_ref(1));
        end
        checks++;
        if (mv_cyc < 0 || mv_cyc !== last_x_cyc + 1) begin
            errors++; $display("FAIL rand_mv_time: got %0d want %0d", mv_cyc, last_x_cyc + 1);
        end
        $display("random mode %0d: %0d pixels total %0d medians %0d/%0d mv at %0d", mode, n, mtotal, cap_xm, cap_ym, mv_cyc);
    endtask

    task automatic test_start_both();
        int hc_at, bc, e;
        pixelValid = 1; pixelData = 1; xAddress = 8'd3; yAddress = 8'd4;
        model_pix(3, 4);
        run_read(0, 1, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || hc_seen !== 0 || mv_cyc !== 241) begin
            errors++; $display("FAIL both_read: %0d wrong bins, clears %0d, mv %0d want 0/0/241", e, hc_seen, mv_cyc);
        end
        do_clear(hc_at, bc);
        checks++;
        if (hc_at !== 241 || bc !== 240) begin
            errors++; $display("FAIL clear_timing: hc %0d busy %0d want 241/240", hc_at, bc);
        end
        checks++;
        if ({saturated, pixelDropped, addrError} !== 3'b000) begin
            errors++; $display("FAIL clear_flags: got %b want 000", {saturated, pixelDropped, addrError});
        end
        run_read(0, 0, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || cap_xm !== 8'd0 || cap_ym !== 8'd0) begin
            errors++; $display("FAIL clear_zero_read: %0d nonzero bins, medians %0d/%0d want 0", e, cap_xm, cap_ym);
        end
        $display("start_both: clear done at %0d, zero read medians %0d/%0d", hc_at, cap_xm, cap_ym);
    endtask

    task automatic test_reset_mid_read();
        int hc_at, bc, e, cyc;
        repeat (5) send_pix(100, 100);
        for (int i = 0; i < 20; i++) send_pix($urandom_range(0, W - 1), $urandom_range(0, H - 1));
        startRead = 1; outReady = 1;
        @(negedge clk);
        startRead = 0;
        cyc = 1;
        while (cyc < 101) begin @(negedge clk); cyc++; end
        checks++;
        if (xValid !== 1'b1 || int'(xHistogramOut) !== mx[100]) begin
            errors++; $display("FAIL mid_bin100: valid %b data %0d want 1 %0d", xValid, xHistogramOut, mx[100]);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({xValid, yValid, busy} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_outs: got %b want 000", {xValid, yValid, busy});
        end
        release_reset(hc_at, bc);
        checks++;
        if (hc_at !== 241 || bc !== 240) begin
            errors++; $display("FAIL mid_reset_clear: hc %0d busy %0d want 241/240", hc_at, bc);
        end
        run_read(0, 0, -1);
        e = count_bin_errs();
        checks++;
        if (e !== 0 || cap_xm !== 8'd0 || cap_ym !== 8'd0 || mv_cyc !== 241) begin
            errors++; $display("FAIL mid_reset_read: %0d nonzero, medians %0d/%0d mv %0d want 0/0/0/241", e, cap_xm, cap_ym, mv_cyc);
        end
        $display("reset_mid_read: clear done at %0d, busy %0d", hc_at, bc);
    endtask

    initial begin
        clk = 0; reset = 1;
        xAddress = 0; yAddress = 0; pixelData = 0; pixelValid = 0;
        startRead = 0; startClear = 0; outReady = 1;
        checks = 0; errors = 0;
        model_clear();
        test_reset();
        test_basic();
        test_saturate();
        test_addr_drop();
        test_random(1);
        test_random(2);
        test_start_both();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/projection_histogram.md
# projection_histogram

Parametrised successor to the team's x/y projection histogram for binary event frames in the median filter datapath. Accumulates per-column and per-row pixel counts with saturation, streams both projections out under a valid/ready handshake, and computes the x and y median coordinates on the fly during read-out. A clear sweep runs automatically after reset or on request. The block sits between the event-frame pixel source and the median/centroid logic.

## Interface
- IMWIDTH, 240, number of x bins (columns)
- IMHEIGHT, 180, number of y bins (rows)
- ADDR_W, 8, width of xAddress/yAddress/median outputs; must hold max(IMWIDTH, IMHEIGHT)-1
- COUNT_W, 8, bin width; bins saturate at 2^COUNT_W-1
- TOTAL_W, 16, width of the pixel-event total counter; saturates at 2^TOTAL_W-1
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- xAddress  in  ADDR_W  column of the incoming pixel
- yAddress  in  ADDR_W  row of the incoming pixel
- pixelData  in  1  pixel value; 1 increments both bins
- pixelValid  in  1  pixel qualifier
- startRead  in  1  pulse: begin read-out (accepted in IDLE only)
- startClear  in  1  pulse: begin clear sweep (accepted in IDLE only)
- outReady  in  1  downstream ready, shared by both streams
- xHistogramOut  out  COUNT_W  current x bin value
- yHistogramOut  out  COUNT_W  current y bin value
- xValid / yValid  out  1  bin valid per stream
- xMedian / yMedian  out  ADDR_W  median bin index of the last read
- medianValid  out  1  one-cycle pulse when both medians are final
- busy  out  1  high in READ and CLEAR
- histogramClear  out  1  one-cycle pulse when a clear sweep completes
- saturated / pixelDropped / addrError  out  1  sticky flags, cleared by reset or clear sweep

## Operation
- States: IDLE, READ, CLEAR. Reset forces CLEAR with index 0; every output is 0 during reset.
- IDLE: on pixelValid && pixelData, bins xHist[xAddress] and yHist[yAddress] increment by 1, saturating; total increments, saturating. A saturating event sets saturated.
- xAddress >= IMWIDTH or yAddress >= IMHEIGHT: the whole pixel is ignored (no bin or total update) and addrError is set.
- pixelValid in READ or CLEAR: pixel is dropped and pixelDropped is set.
- IDLE + startRead -> READ; IDLE + startClear -> CLEAR; both high together: read wins, clear is ignored. The pixel in the same cycle is still accumulated.
- READ: each axis streams bins 0..N-1 in order. A bin advances only on valid && outReady. Data is held stable while valid && !outReady. A stream drops valid after its last bin is accepted; the y stream finishes first. READ -> IDLE once both streams are done.
- Median, per axis: cum += bin on each accepted bin. The first index i with 2*cum >= total is latched as the median. If total == 0, median = 0. Arithmetic runs at TOTAL_W+1 bits, with no overflow.
- CLEAR: zero bin[idx] on both axes at idx = 0..max(IMWIDTH,IMHEIGHT)-1, one per cycle; the y axis skips idx >= IMHEIGHT. The total and sticky flags are zeroed. CLEAR -> IDLE with a histogramClear pulse.
- startRead/startClear outside IDLE are ignored. reset during READ or CLEAR aborts the operation and restarts CLEAR.

## Timing
- Accumulate is a single-cycle read-modify-write. Back-to-back pixels to the same bin count correctly.
- startRead at cycle t: xValid/yValid = 1 with bin 0 at t+1. Throughput is 1 bin/cycle with outReady held high.
- Read duration is max(IMWIDTH, IMHEIGHT) cycles minimum (240 for the defaults). medianValid pulses the cycle after the last x acceptance, i.e. t+241 at full rate.
- xMedian/yMedian hold until the next medianValid.
- Clear lasts max(IMWIDTH,IMHEIGHT) cycles. histogramClear pulses in the cycle the state returns to IDLE. busy is 1 for every READ/CLEAR cycle.
- After reset deasserts, the block is unavailable for 240 cycles (busy=1).

## Structure
- Package projection_histogram_pkg holds:
  - the state enum (IDLE/READ/CLEAR)
  - a clog2 function
  - a bin saturating-add helper
  - default parameter constants
- Sub-module histogram_axis (parameters DEPTH, COUNT_W, TOTAL_W), instantiated twice. It contains:
  - the bin array
  - the saturating increment
  - the clear port
  - the read stream register with the valid/ready hold
  - the cumulative-sum median tracker
- The top level holds the FSM, shared index, total counter, address check and sticky flags.

## Test plan
- Reset, then 3 pixels at (5,7) and 1 at (200,179); read with outReady=1 -> bins x5=3, x200=1, y7=3, y179=1, all others 0; xMedian=5, yMedian=7; medianValid at t+241.
- 300 pixels at (0,0) -> x0 = y0 = 255, saturated=1, total=300; read -> xMedian=0.
- Read with outReady toggled 1,0,0,1… -> each bin appears exactly once, and output is stable across low-ready cycles.
- Pixel at x=240 -> no bin or total change, addrError=1. Pixel during READ -> pixelDropped=1, bins unchanged.
- startRead and startClear in the same IDLE cycle -> READ entered, no clear. startClear afterwards -> histogramClear after 240 cycles, and a subsequent read returns all zeros with xMedian = yMedian = 0.
- reset asserted mid-READ at bin 100 -> valids drop and CLEAR runs 240 cycles, then the next read returns all zeros.
